// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/compare ops, iterative shift-add multiply.
// Define SEQ_ALU_DIV_EN to build the iterative signed divider (DIV/REM); otherwise they are illegal.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opsel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h04, OP_OR   = 6'h05;
  localparam logic [5:0] OP_XOR  = 6'h06, OP_MUL  = 6'h08, OP_DIV  = 6'h09, OP_REM  = 6'h0A;
  localparam logic [5:0] OP_MVHI = 6'h0B, OP_NAND = 6'h0C, OP_NOR  = 6'h0D, OP_XNOR = 6'h0E;
  localparam logic [5:0] OP_F    = 6'h10, OP_EQ   = 6'h11, OP_LT   = 6'h12, OP_LTE  = 6'h13;
  localparam logic [5:0] OP_EQZ  = 6'h15, OP_LTZ  = 6'h16, OP_LTEZ = 6'h17, OP_T    = 6'h18;
  localparam logic [5:0] OP_NE   = 6'h19, OP_GTE  = 6'h1A, OP_GT   = 6'h1B, OP_NEZ  = 6'h1D;
  localparam logic [5:0] OP_GTEZ = 6'h1E, OP_GTZ  = 6'h1F, OP_JAL  = 6'h20;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [5:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_r, shf_r, opr_r;
  logic [WIDTH-1:0] acc_nx_s, shf_nx_s, opr_nx_s;
  logic [WIDTH-1:0] result_r, fin_res_s;
  logic             err_r, fin_err_s;
  logic             multi_s, last_s;
`ifdef SEQ_ALU_DIV_EN
  logic             dz_r, a_neg_r, q_neg_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] rem_sh_s;
  logic [WIDTH:0]   trial_s;
`endif

  function automatic logic [WIDTH-1:0] b2w(input logic c);
    return {{(WIDTH-1){1'b0}}, c};
  endfunction

  function automatic logic [WIDTH-1:0] abs_fn(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Returns {err, result} for every opcode that completes in one cycle (illegal included).
  function automatic logic [WIDTH:0] single_op(input logic [5:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] sx, sy;
    logic [WIDTH-1:0]        r;
    logic                    e;
    logic                    z;
    sx = $signed(x);
    sy = $signed(y);
    z  = (x == {WIDTH{1'b0}});
    r  = {WIDTH{1'b0}};
    e  = 1'b0;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_MVHI: r = {y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_JAL:  r = x + {y[WIDTH-3:0], 2'b00};
      OP_F:    r = {WIDTH{1'b0}};
      OP_EQ:   r = b2w(sx == sy);
      OP_LT:   r = b2w(sx < sy);
      OP_LTE:  r = b2w(sx <= sy);
      OP_EQZ:  r = b2w(z);
      OP_LTZ:  r = b2w(x[WIDTH-1]);
      OP_LTEZ: r = b2w(x[WIDTH-1] | z);
      OP_T:    r = b2w(1'b1);
      OP_NE:   r = b2w(sx != sy);
      OP_GTE:  r = b2w(sx >= sy);
      OP_GT:   r = b2w(sx > sy);
      OP_NEZ:  r = b2w(!z);
      OP_GTEZ: r = b2w(!x[WIDTH-1]);
      OP_GTZ:  r = b2w(!(x[WIDTH-1] | z));
      default: begin
        r = {WIDTH{1'b0}};
        e = 1'b1;
      end
    endcase
    return {e, r};
  endfunction

  // Which incoming opcodes take the iterative path.
  always_comb begin
    multi_s = (opsel == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
    multi_s = multi_s | (opsel == OP_DIV) | (opsel == OP_REM);
`endif
  end

  // One shift-add (MUL) or restoring-subtract (DIV/REM) step on magnitudes.
  always_comb begin
    acc_nx_s = acc_r;
    shf_nx_s = shf_r;
    opr_nx_s = opr_r;
`ifdef SEQ_ALU_DIV_EN
    rem_sh_s = {WIDTH{1'b0}};
    trial_s  = {(WIDTH+1){1'b0}};
`endif
    if (op_r == OP_MUL) begin
      acc_nx_s = opr_r[0] ? (acc_r + shf_r) : acc_r;
      shf_nx_s = {shf_r[WIDTH-2:0], 1'b0};
      opr_nx_s = {1'b0, opr_r[WIDTH-1:1]};
    end else begin
`ifdef SEQ_ALU_DIV_EN
      // Partial remainder stays below the divisor magnitude, so its MSB is always clear.
      rem_sh_s = {acc_r[WIDTH-2:0], shf_r[WIDTH-1]};
      trial_s  = {1'b0, rem_sh_s} - {1'b0, opr_r};
      if (trial_s[WIDTH]) begin
        acc_nx_s = rem_sh_s;
        shf_nx_s = {shf_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_nx_s = trial_s[WIDTH-1:0];
        shf_nx_s = {shf_r[WIDTH-2:0], 1'b1};
      end
`else
      acc_nx_s = acc_r;
`endif
    end
  end

  // Result of the last iteration, with sign correction and divide-by-zero override.
  always_comb begin
    fin_res_s = {WIDTH{1'b0}};
    fin_err_s = 1'b0;
    case (op_r)
      OP_MUL: fin_res_s = acc_nx_s;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: begin
        if (dz_r) begin
          fin_res_s = {WIDTH{1'b1}};
          fin_err_s = 1'b1;
        end else begin
          fin_res_s = q_neg_r ? (~shf_nx_s + {{(WIDTH-1){1'b0}}, 1'b1}) : shf_nx_s;
        end
      end
      OP_REM: begin
        if (dz_r) begin
          fin_res_s = a_r;
          fin_err_s = 1'b1;
        end else begin
          fin_res_s = a_neg_r ? (~acc_nx_s + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_nx_s;
        end
      end
`endif
      default: begin
        fin_res_s = {WIDTH{1'b0}};
        fin_err_s = 1'b1;
      end
    endcase
  end

  assign last_s = (cnt_r == LAST);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = multi_s ? BUSY : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r     <= 6'h00;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      shf_r    <= {WIDTH{1'b0}};
      opr_r    <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      err_r    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      dz_r     <= 1'b0;
      a_neg_r  <= 1'b0;
      q_neg_r  <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r  <= opsel;
            cnt_r <= {CW{1'b0}};
            if (multi_s) begin
              acc_r <= {WIDTH{1'b0}};
`ifdef SEQ_ALU_DIV_EN
              if (opsel == OP_MUL) begin
                shf_r <= a;
                opr_r <= b;
              end else begin
                shf_r   <= abs_fn(a);
                opr_r   <= abs_fn(b);
                dz_r    <= (b == {WIDTH{1'b0}});
                a_neg_r <= a[WIDTH-1];
                q_neg_r <= a[WIDTH-1] ^ b[WIDTH-1];
                a_r     <= a;
              end
`else
              shf_r <= a;
              opr_r <= b;
`endif
            end else begin
              {err_r, result_r} <= single_op(opsel, a, b);
            end
          end
        end
        BUSY: begin
          acc_r <= acc_nx_s;
          shf_r <= shf_nx_s;
          opr_r <= opr_nx_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            result_r <= fin_res_s;
            err_r    <= fin_err_s;
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign result    = result_r;
  assign err       = err_r;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus randomized traffic against a reference model.
module tb_seq_alu;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [5:0]   opsel = 6'h00;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, err;
  logic [W-1:0] result;

  logic         iv16 = 1'b0, or16 = 1'b1, ir16, ov16, err16;
  logic [5:0]   op16 = 6'h00;
  logic [15:0]  a16 = 16'h0, b16 = 16'h0, res16;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .opsel(opsel),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16), .opsel(op16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .result(res16), .err(err16)
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0;
  int cyc = 0;
  int or_mode = 1;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bw(input bit c);
    return c ? W'(1) : W'(0);
  endfunction

  // Reference model: plain signed arithmetic on 64-bit integers.
  function automatic void model(input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic e, output int lat);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; e = 1'b0; lat = 1;
    case (op)
      6'h00: r = W'(sx + sy);
      6'h01: r = W'(sx - sy);
      6'h04: r = x & y;
      6'h05: r = x | y;
      6'h06: r = x ^ y;
      6'h0C: r = ~(x & y);
      6'h0D: r = ~(x | y);
      6'h0E: r = ~(x ^ y);
      6'h0B: r = y << (W / 2);
      6'h20: r = W'(sx + sy * 4);
      6'h10: r = '0;
      6'h11: r = bw(sx == sy);
      6'h12: r = bw(sx < sy);
      6'h13: r = bw(sx <= sy);
      6'h15: r = bw(sx == 0);
      6'h16: r = bw(sx < 0);
      6'h17: r = bw(sx <= 0);
      6'h18: r = bw(1'b1);
      6'h19: r = bw(sx != sy);
      6'h1A: r = bw(sx >= sy);
      6'h1B: r = bw(sx > sy);
      6'h1D: r = bw(sx != 0);
      6'h1E: r = bw(sx >= 0);
      6'h1F: r = bw(sx > 0);
      6'h08: begin r = W'(sx * sy); lat = W + 1; end
`ifdef SEQ_ALU_DIV_EN
      6'h09: begin
        lat = W + 1;
        if (sy == 0) begin r = '1; e = 1'b1; end
        else r = W'(sx / sy);
      end
      6'h0A: begin
        lat = W + 1;
        if (sy == 0) begin r = x; e = 1'b1; end
        else r = W'(sx % sy);
      end
`endif
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // Present one request, wait for the handshake, record the expectation.
  task automatic issue(input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit rel, output int acc);
    exp_t e;
    int n;
    model(op, x, y, e.res, e.err, e.lat);
    @(posedge clk); #1;
    if (rel) reset_n = 1'b1;
    in_valid = 1'b1; opsel = op; a = x; b = y;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    if (rel) check("first_accept_wait", 64'(n), 64'd0);
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      acc = cyc;
      in_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    acc = cyc;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; opsel = 6'($urandom); a = $urandom; b = $urandom;
  endtask

  // Monitor: pop on first sight of out_valid, then require stability until consumed.
  exp_t cur;
  bit holding = 1'b0, after_hs = 1'b0;
  int last_consume = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      holding = 1'b0;
      after_hs = 1'b0;
    end else begin
      if (after_hs) begin
        check("in_ready_after_release", 64'(in_ready), 64'd1);
        after_hs = 1'b0;
      end
      if (out_valid) begin
        if (!holding) begin
          if (sbq.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
            cur.res = result; cur.err = err;
          end else begin
            cur = sbq.pop_front();
            check("result", 64'(result), 64'(cur.res));
            check("err", 64'(err), 64'(cur.err));
            check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
          end
          holding = 1'b1;
        end else begin
          check("hold_result", 64'(result), 64'(cur.res));
          check("hold_err", 64'(err), 64'(cur.err));
        end
        check("in_ready_in_done", 64'(in_ready), 64'd0);
        if (out_ready) begin
          holding = 1'b0;
          after_hs = 1'b1;
          last_consume = cyc;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0: out_ready = 1'($urandom_range(0, 1));
        1: out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic drain();
    int n = 0;
    or_mode = 1;
    while ((sbq.size() != 0 || holding) && n < 3000) begin n++; @(negedge clk); end
    check("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  task automatic run16(input logic [5:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] er, input logic ee);
    int n = 0;
    @(posedge clk); #1;
    iv16 = 1'b1; op16 = op; a16 = x; b16 = y;
    @(negedge clk);
    while (!ir16 && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov16 && n < 100) begin n++; @(negedge clk); end
    check("w16_out_valid", 64'(ov16), 64'd1);
    check("w16_result", 64'(res16), 64'(er));
    check("w16_err", 64'(err16), 64'(ee));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return MINV;
      4: return MAXV;
      5: return W'(int'($urandom_range(0, 20)) - 10);
      default: return W'($urandom);
    endcase
  endfunction

  logic [5:0] op_tab [27] = '{6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h0C, 6'h0D, 6'h0E, 6'h0B,
                              6'h20, 6'h10, 6'h11, 6'h12, 6'h13, 6'h15, 6'h16, 6'h17, 6'h18,
                              6'h19, 6'h1A, 6'h1B, 6'h1D, 6'h1E, 6'h1F, 6'h08, 6'h09, 6'h0A};

  initial begin
    int acc, acc_add, n;
    logic [5:0] op;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    issue(6'h00, 32'h7FFF_FFFF, 32'h1, 1'b1, acc);
    issue(6'h08, W'(-3), W'(7), 1'b0, acc);
`ifdef SEQ_ALU_DIV_EN
    issue(6'h09, W'(-7), W'(2), 1'b0, acc);
    issue(6'h0A, W'(-7), W'(2), 1'b0, acc);
    issue(6'h09, W'(5), W'(0), 1'b0, acc);
    issue(6'h0A, W'(-5), W'(0), 1'b0, acc);
    issue(6'h09, MINV, '1, 1'b0, acc);
`else
    issue(6'h09, W'(-7), W'(2), 1'b0, acc);
    issue(6'h0A, W'(-7), W'(2), 1'b0, acc);
`endif
    issue(6'h3F, W'(3), W'(4), 1'b0, acc);
    drain();

    run16(6'h0B, 16'h1234, 16'h00AB, 16'hAB00, 1'b0);
    run16(6'h3F, 16'h0001, 16'h0002, 16'h0000, 1'b1);

    // Output held back for 10 cycles with a competing request pending.
    or_mode = 2;
    issue(6'h1D, W'(5), W'(0), 1'b0, acc);
    fork
      issue(6'h00, W'(2), W'(3), 1'b0, acc_add);
      begin
        n = 0;
        while (!out_valid && n < 50) begin n++; @(negedge clk); end
        repeat (10) @(negedge clk);
        or_mode = 1;
      end
    join
    check("reaccept_cycle", 64'(acc_add), 64'(last_consume + 1));
    drain();

    or_mode = 0;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 26)];
      issue(op, pick(), pick(), 1'b0, acc);
    end
    drain();

    // Reset in the middle of a multiply discards it.
    issue(6'h08, W'(123), W'(456), 1'b0, acc);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    sbq.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("no_stale_out_valid", 64'(out_valid), 64'd0);
    end
    issue(6'h01, W'(9), W'(4), 1'b0, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are even integers from 16 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operation request.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port opsel, input, 6 bits: operation code.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: signed operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-010 The block SHALL have port result, output, WIDTH bits: operation result.
REQ-011 The block SHALL have port err, output, 1 bit: illegal opcode or divide-by-zero, qualified by out_valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 A request SHALL be accepted when in_valid & in_ready; opsel, a and b SHALL be captured on that edge and their later changes ignored.
REQ-015 Single-cycle ops SHALL go IDLE->DONE, with out_valid 1 cycle after acceptance:
- ADD 0x00, SUB 0x01, AND 0x04, OR 0x05, XOR 0x06, NAND 0x0C, NOR 0x0D, XNOR 0x0E.
- MVHI 0x0B = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
- JAL 0x20 = a + (b<<2).
REQ-016 Compare ops SHALL use signed compares and return 1 or 0 zero-extended:
- F 0x10, EQ 0x11, LT 0x12, LTE 0x13, EQZ 0x15, LTZ 0x16, LTEZ 0x17.
- T 0x18, NE 0x19, GTE 0x1A, GT 0x1B, NEZ 0x1D (a!=0), GTEZ 0x1E, GTZ 0x1F.
REQ-017 ADD, SUB and JAL SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-018 MUL 0x08 SHALL go IDLE->BUSY, run WIDTH iterations of shift-add, then go to DONE; result SHALL be the low WIDTH bits of a*b, with out_valid exactly WIDTH+1 cycles after acceptance.
REQ-019 DIV 0x09 and REM 0x0A SHALL be signed with the quotient truncated toward zero and the remainder taking the sign of a, with the same WIDTH+1 latency as MUL.
REQ-020 Division by zero SHALL complete with the same latency and give: DIV result all-ones, REM result = a, err=1.
REQ-021 DIV of the most negative value by -1 SHALL give result = the most negative value and err=0.
REQ-022 Any other opcode SHALL go to DONE in 1 cycle with result 0 and err=1.
REQ-023 In DONE, result and err SHALL hold stable until out_valid & out_ready, which returns the FSM to IDLE on that edge; in_ready rises the following cycle, with no same-cycle re-accept.
REQ-024 in_valid SHALL be ignored in BUSY and DONE, and out_ready SHALL be ignored outside DONE.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, result 0, err 0, out_valid 0 and in_ready 1, and clear the iteration counter and datapath registers.
REQ-026 Reset asserted during BUSY or DONE SHALL discard the in-flight operation, with no result delivered after release.
REQ-027 The first acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro SEQ_ALU_DIV_EN defined SHALL compile in the iterative divider with DIV and REM behaving per REQ-019 to REQ-021.
REQ-029 Macro SEQ_ALU_DIV_EN undefined SHALL remove the divider, and DIV and REM SHALL then be treated as illegal opcodes per REQ-022 (1-cycle latency, result 0, err=1); MUL SHALL be unaffected.

Verification
REQ-030 Reset, then ADD a=0x7FFFFFFF b=1 with out_ready=1 -> out_valid 1 cycle later, result 0x80000000, err 0.
REQ-031 MUL a=-3 b=7 (WIDTH=32) -> out_valid exactly 33 cycles after acceptance, result 0xFFFFFFEB.
REQ-032 With SEQ_ALU_DIV_EN: DIV a=-7 b=2 gives 0xFFFFFFFD; REM a=-7 b=2 gives 0xFFFFFFFF; DIV a=5 b=0 gives 0xFFFFFFFF with err=1.
REQ-033 Hold out_ready=0 for 10 cycles after completion of NEZ a=5 -> result stays 1 and in_ready stays 0; a new in_valid is not accepted until 1 cycle after out_ready=1.
REQ-034 Assert reset_n low mid-MUL (cycle 10) -> outputs immediately at reset values; after release, no stale out_valid, and a new SUB 9-4 gives 5.
REQ-035 Opcode 0x3F, and WIDTH=16 MVHI b=0x00AB -> results 0 with err=1, and 0xAB00 respectively.
